// File: rtl/display_scheduler.sv
// Time-shares a 4-digit seven-segment display between two 16-bit sources with
// frame-aligned round-robin arbitration. Optional: DISPLAY_LEADING_ZERO_BLANK_EN.
module display_scheduler #(
    parameter int SCAN_DIV    = 1024,
    parameter int HOLD_FRAMES = 16
) (
    input  logic        MHzclk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  grant,
    output logic [3:0]  AN,
    output logic [3:0]  digit,
    output logic        frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, SWITCH} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [1:0]    idx, idx_nx;
    logic [15:0]   shadow, shadow_nx;
    logic [3:0]    show, show_nx;
    logic [HW-1:0] hold, hold_nx, hold_inc;
    logic          last, last_nx;
    logic          take, pick;
    logic          wrap, boundary, owning_nx;

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    // Slot i is lit only if some nibble at or above i is nonzero; slot 0 always lit.
    function automatic logic [3:0] lz_mask(input logic [15:0] d);
        lz_mask = {|d[15:12], |d[15:8], |d[15:4], 1'b1};
    endfunction
`endif

    assign wrap      = (cnt == CNT_LAST);
    assign boundary  = wrap && (idx == 2'd3);
    assign idx_nx    = idx + 2'd1;
    assign owning_nx = (state_nx == OWN0) || (state_nx == OWN1);

    always_comb begin
        state_nx  = state;
        hold_nx   = hold;
        last_nx   = last;
        shadow_nx = shadow;
        take      = 1'b0;
        pick      = 1'b0;
        hold_inc  = (hold == HOLD_MAX) ? hold : hold + 1'b1;
        if (boundary) begin
            case (state)
                IDLE, SWITCH: begin
                    if (req0 && req1) begin
                        take = 1'b1;
                        pick = ~last;
                    end else if (req0 || req1) begin
                        take = 1'b1;
                        pick = req1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                OWN0: begin
                    if (!req0)                              state_nx = req1 ? SWITCH : IDLE;
                    else if (req1 && hold_inc == HOLD_MAX)  state_nx = SWITCH;
                    else begin
                        hold_nx   = hold_inc;
                        shadow_nx = data0;
                    end
                end
                OWN1: begin
                    if (!req1)                              state_nx = req0 ? SWITCH : IDLE;
                    else if (req0 && hold_inc == HOLD_MAX)  state_nx = SWITCH;
                    else begin
                        hold_nx   = hold_inc;
                        shadow_nx = data1;
                    end
                end
                default: state_nx = IDLE;
            endcase
            if (take) begin
                state_nx  = pick ? OWN1 : OWN0;
                hold_nx   = '0;
                last_nx   = pick;
                shadow_nx = pick ? data1 : data0;
            end
        end
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        show_nx = lz_mask(shadow_nx);
`else
        show_nx = 4'b1111;
`endif
    end

    always_ff @(posedge MHzclk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= 2'd0;
            hold       <= '0;
            last       <= 1'b1;
            shadow     <= 16'h0000;
            show       <= 4'b1111;
            grant      <= 2'b00;
            AN         <= 4'b1111;
            digit      <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            hold       <= hold_nx;
            last       <= last_nx;
            shadow     <= shadow_nx;
            show       <= show_nx;
            frame_done <= boundary;
            if (boundary) grant <= {state_nx == OWN1, state_nx == OWN0};
            // Slot change: AN and digit always move together, one cycle after the wrap.
            if (wrap) begin
                cnt <= '0;
                idx <= idx_nx;
                if (owning_nx && show_nx[idx_nx]) begin
                    AN    <= ~(4'b0001 << idx_nx);
                    digit <= shadow_nx[{idx_nx, 2'b00} +: 4];
                end else begin
                    AN    <= 4'b1111;
                    digit <= 4'h0;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler (SCAN_DIV=4, HOLD_FRAMES=2) with a
// frame-level reference model compared every cycle plus literal expectations.
module tb_display_scheduler;

    localparam int SD = 4;
    localparam int HF = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] data0 = 16'h0, data1 = 16'h0;
    logic [1:0]  grant;
    logic [3:0]  AN, digit;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    display_scheduler #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
        .MHzclk(clk), .reset(reset), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .grant(grant), .AN(AN),
        .digit(digit), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_show(input logic [15:0] d);
        int top;
        top = 0;
        for (int s = 0; s < 4; s++) if (d[4*s +: 4] != 4'h0) top = s;
`ifndef DISPLAY_LEADING_ZERO_BLANK_EN
        top = 3;
`endif
        for (int s = 0; s < 4; s++) exp_show[s] = (s <= top);
    endfunction

    // Owner codes: 0 none, 1 source 0, 2 source 1, 3 blank switch frame.
    int          m_k, m_owner, m_fo, m_last, m_me, m_pick, m_slot;
    logic        m_mine, m_other, m_shown;
    logic [15:0] m_snap = 16'h0;
    logic [3:0]  m_mask, m_an, m_dig;
    logic [1:0]  m_grant;

    always @(posedge clk) begin
        if (!reset) begin
            m_k = 0; m_owner = 0; m_fo = 0; m_last = 1;
        end else begin
            m_k++;
            if (m_k % FRAME == 0) begin
                if (m_owner == 1 || m_owner == 2) begin
                    m_me    = m_owner - 1;
                    m_mine  = (m_me == 1) ? req1 : req0;
                    m_other = (m_me == 1) ? req0 : req1;
                    if (m_fo < HF) m_fo++;
                    if (!m_mine)                  m_owner = m_other ? 3 : 0;
                    else if (m_other && m_fo == HF) m_owner = 3;
                    else                          m_snap = (m_me == 1) ? data1 : data0;
                end else begin
                    m_pick = -1;
                    if (req0 && req1) m_pick = 1 - m_last;
                    else if (req0)    m_pick = 0;
                    else if (req1)    m_pick = 1;
                    if (m_pick < 0) m_owner = 0;
                    else begin
                        m_owner = m_pick + 1; m_fo = 0; m_last = m_pick;
                        m_snap  = (m_pick == 1) ? data1 : data0;
                    end
                end
            end
            #1;
            if (reset) begin
                m_slot  = (m_k / SD) % 4;
                m_mask  = exp_show(m_snap);
                m_shown = (m_owner == 1 || m_owner == 2) && m_mask[m_slot];
                m_an    = m_shown ? ~(4'b0001 << m_slot) : 4'b1111;
                m_dig   = m_shown ? m_snap[4*m_slot +: 4] : 4'h0;
                m_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
                chk("model_grant", {14'h0, grant}, {14'h0, m_grant});
                chk("model_AN", {12'h0, AN}, {12'h0, m_an});
                chk("model_digit", {12'h0, digit}, {12'h0, m_dig});
                chk("model_frame_done", {15'h0, frame_done}, {15'h0, (m_k % FRAME == 0)});
            end
        end
    end

    task automatic wait_grant(input logic [1:0] g, input string name);
        int n;
        n = 0;
        while (grant !== g && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk(name, {14'h0, grant}, {14'h0, g});
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    int          pulses, lit;
    logic [1:0]  tie_seq [8] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};

    initial begin
        // Reset values while held in reset.
        wait_neg(3);
        chk("rst_AN", {12'h0, AN}, 16'h000F);
        chk("rst_grant", {14'h0, grant}, 16'h0);
        chk("rst_digit", {12'h0, digit}, 16'h0);
        chk("rst_frame_done", {15'h0, frame_done}, 16'h0);
        reset = 1'b1;

        // Idle: two frames, one frame_done pulse each.
        pulses = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (frame_done) pulses++;
        end
        chk("idle_pulses", 16'(pulses), 16'd2);
        chk("idle_AN", {12'h0, AN}, 16'h000F);

        // Single owner; data change mid-frame must not tear the frame.
        req0 = 1'b1; data0 = 16'h1234;
        wait_grant(2'b01, "own0_grant");
        chk("own0_s0_AN", {12'h0, AN}, 16'h000E);
        chk("own0_s0_digit", {12'h0, digit}, 16'h0004);
        wait_neg(SD);
        chk("own0_s1_AN", {12'h0, AN}, 16'h000D);
        chk("own0_s1_digit", {12'h0, digit}, 16'h0003);
        data0 = 16'h5678;
        wait_neg(SD);
        chk("own0_s2_AN", {12'h0, AN}, 16'h000B);
        chk("own0_s2_digit", {12'h0, digit}, 16'h0002);
        wait_neg(SD);
        chk("own0_s3_AN", {12'h0, AN}, 16'h0007);
        chk("own0_s3_digit", {12'h0, digit}, 16'h0001);
        wait_neg(SD);
        chk("own0_newframe_digit", {12'h0, digit}, 16'h0008);

        // Release with no other requester -> idle.
        req0 = 1'b0;
        wait_grant(2'b00, "release_idle");

        // Tie from reset, hold 2 frames, blank between owners.
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
        wait_neg(3);
        reset = 1'b1;
        for (int f = 0; f < 8; f++) begin
            wait_neg(FRAME / 2);
            chk("tie_grant", {14'h0, grant}, {14'h0, tie_seq[f]});
            wait_neg(FRAME / 2);
        end

        // Owner 0 drops with req1 high: one blank frame, then source 1.
        req0 = 1'b0;
        wait_neg(FRAME / 2);
        chk("drop_pre", {14'h0, grant}, 16'h0001);
        wait_neg(FRAME);
        chk("drop_blank", {14'h0, grant}, 16'h0000);
        wait_neg(FRAME);
        chk("drop_new", {14'h0, grant}, 16'h0002);

        // Leading-zero handling on source 0.
        req1 = 1'b0; req0 = 1'b1; data0 = 16'h0050;
        wait_neg(FRAME + FRAME / 2);
        data0 = 16'h0000;
        lit = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (AN != 4'hF) lit++;
            @(negedge clk);
        end
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        chk("lz_0050_lit", 16'(lit), 16'd8);
`else
        chk("lz_0050_lit", 16'(lit), 16'd16);
`endif
        lit = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (AN != 4'hF) lit++;
            @(negedge clk);
        end
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        chk("lz_0000_lit", 16'(lit), 16'd4);
`else
        chk("lz_0000_lit", 16'(lit), 16'd16);
`endif

        // Asynchronous reset mid-frame while source 1 owns.
        req0 = 1'b0; req1 = 1'b1; data1 = 16'h0A0B;
        wait_grant(2'b10, "async_pre_grant");
        wait_neg(2);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_AN", {12'h0, AN}, 16'h000F);
        chk("async_grant", {14'h0, grant}, 16'h0);
        chk("async_frame_done", {15'h0, frame_done}, 16'h0);
        chk("async_digit", {12'h0, digit}, 16'h0);
        wait_neg(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
